// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the memory-stage controller (master) and data memory (slave).
// Handshake: master raises req with we/addr/wdata stable and holds them until it drops req;
// slave signals completion by asserting ack for one cycle, with rdata valid in that cycle.
interface mem_access_ctrl_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        ack;
    logic [15:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: issues load/store transactions to data memory, stalls upstream
// while they are outstanding, and forwards ALU results to write-back with one cycle latency.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              alu_result,
    input  logic [15:0]              rdata2,
    input  logic                     mem_wen,
    input  logic                     mem_ren,
    input  logic                     mem_to_reg,
    input  logic                     reg_wen,
    input  logic [3:0]               reg_waddr,
    mem_access_ctrl_if.master        dmem,
    output logic                     stall,
    output logic                     wb_valid,
    output logic [15:0]              wb_data,
    output logic                     wb_reg_wen,
    output logic [3:0]               wb_reg_waddr,
    output logic                     err,
    output logic [1:0]               fsm_state
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        lat_m2r_q, lat_m2r_d;
    logic        lat_wen_q, lat_wen_d;
    logic [3:0]  lat_waddr_q, lat_waddr_d;
    logic        req_d, we_d;
    logic [15:0] addr_d, wdata_d;
    logic        wb_valid_d, wb_reg_wen_d, err_d;
    logic [15:0] wb_data_d;
    logic [3:0]  wb_reg_waddr_d;
    logic        mem_op;
    logic        timeout;

    assign mem_op    = mem_ren | mem_wen;
    // Counter is compared before it increments, so it never passes TIMEOUT_LAST.
    assign timeout   = !dmem.ack && (cnt_q == TIMEOUT_LAST);
    assign fsm_state = state_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        stall          = 1'b0;
        cnt_d          = cnt_q;
        lat_m2r_d      = lat_m2r_q;
        lat_wen_d      = lat_wen_q;
        lat_waddr_d    = lat_waddr_q;
        req_d          = dmem.req;
        we_d           = dmem.we;
        addr_d         = dmem.addr;
        wdata_d        = dmem.wdata;
        wb_valid_d     = 1'b0;
        wb_data_d      = wb_data;
        wb_reg_wen_d   = 1'b0;
        wb_reg_waddr_d = wb_reg_waddr;
        err_d          = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    stall       = 1'b1;
                    state_d     = ACCESS;
                    req_d       = 1'b1;
                    we_d        = mem_wen;
                    addr_d      = alu_result;
                    wdata_d     = rdata2;
                    lat_m2r_d   = mem_to_reg;
                    lat_wen_d   = reg_wen;
                    lat_waddr_d = reg_waddr;
                    cnt_d       = 8'd0;
                end else begin
                    wb_valid_d     = 1'b1;
                    wb_data_d      = alu_result;
                    wb_reg_wen_d   = reg_wen;
                    wb_reg_waddr_d = reg_waddr;
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (dmem.ack) begin
                    state_d        = DONE;
                    req_d          = 1'b0;
                    wb_valid_d     = 1'b1;
                    wb_data_d      = lat_m2r_q ? dmem.rdata : dmem.addr;
                    wb_reg_wen_d   = lat_wen_q;
                    wb_reg_waddr_d = lat_waddr_q;
                end else if (timeout) begin
                    state_d        = DONE;
                    req_d          = 1'b0;
                    wb_valid_d     = 1'b1;
                    wb_data_d      = 16'h0000;
                    wb_reg_waddr_d = lat_waddr_q;
                    err_d          = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            // EXE/MEM still holds the finished op here; releasing stall lets it advance.
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= 8'd0;
            lat_m2r_q    <= 1'b0;
            lat_wen_q    <= 1'b0;
            lat_waddr_q  <= 4'd0;
            dmem.req     <= 1'b0;
            dmem.we      <= 1'b0;
            dmem.addr    <= 16'h0000;
            dmem.wdata   <= 16'h0000;
            wb_valid     <= 1'b0;
            wb_data      <= 16'h0000;
            wb_reg_wen   <= 1'b0;
            wb_reg_waddr <= 4'd0;
            err          <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            lat_m2r_q    <= lat_m2r_d;
            lat_wen_q    <= lat_wen_d;
            lat_waddr_q  <= lat_waddr_d;
            dmem.req     <= req_d;
            dmem.we      <= we_d;
            dmem.addr    <= addr_d;
            dmem.wdata   <= wdata_d;
            wb_valid     <= wb_valid_d;
            wb_data      <= wb_data_d;
            wb_reg_wen   <= wb_reg_wen_d;
            wb_reg_waddr <= wb_reg_waddr_d;
            err          <= err_d;
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed instruction stream, a data-memory responder that
// checks requests, and a write-back monitor popping an expected-retirement queue.
module tb_mem_access_ctrl;
    localparam int TO = 4;
    localparam int W  = 23;  // {check_waddr, err, reg_wen, waddr[3:0], data[15:0]}

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] alu_result = '0;
    logic [15:0] rdata2 = '0;
    logic        mem_wen = 1'b0, mem_ren = 1'b0, mem_to_reg = 1'b0, reg_wen = 1'b0;
    logic [3:0]  reg_waddr = '0;
    logic        stall, wb_valid, wb_reg_wen, err;
    logic [15:0] wb_data;
    logic [3:0]  wb_reg_waddr;
    logic [1:0]  fsm_state;

    mem_access_ctrl_if dmem_bus();

    mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .alu_result(alu_result), .rdata2(rdata2),
        .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_to_reg(mem_to_reg),
        .reg_wen(reg_wen), .reg_waddr(reg_waddr), .dmem(dmem_bus),
        .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data),
        .wb_reg_wen(wb_reg_wen), .wb_reg_waddr(wb_reg_waddr), .err(err),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          ack_at;
        int          req_len;
    } mem_exp_t;

    int             checks = 0;
    int             errors = 0;
    logic [W-1:0]   exp_q[$];
    mem_exp_t       mem_q[$];
    logic           stray_ack = 1'b0;
    logic           mon_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic care_wa, input logic e, input logic rw,
                                        input logic [3:0] wa, input logic [15:0] d);
        return {care_wa, e, rw, wa, d};
    endfunction

    task automatic add_mem(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [15:0] rd, input int ack_at, input int req_len);
        mem_exp_t m;
        m.we = we; m.addr = addr; m.wdata = wdata; m.rdata = rd;
        m.ack_at = ack_at; m.req_len = req_len;
        mem_q.push_back(m);
    endtask

    // Present one instruction, hold it while stall is high, and check the stall length.
    task automatic issue(input logic [15:0] a, input logic [15:0] d2, input logic wen,
                         input logic ren, input logic m2r, input logic rw, input logic [3:0] wa,
                         input int stall_exp, input logic [W-1:0] exp_word);
        int n_stall;
        int guard;
        n_stall = 0;
        guard   = 0;
        alu_result = a; rdata2 = d2; mem_wen = wen; mem_ren = ren;
        mem_to_reg = m2r; reg_wen = rw; reg_waddr = wa;
        exp_q.push_back(exp_word);
        forever begin
            @(negedge clk);
            if (!stall) break;
            n_stall++;
            guard++;
            if (guard > 100) begin
                check("stall_bound", 32'(guard), 32'd100);
                break;
            end
        end
        check("stall_cycles", 32'(n_stall), 32'(stall_exp));
        @(posedge clk);
        #1;
    endtask

    // Write-back monitor.
    initial begin
        logic         prev_done;
        logic [W-1:0] e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (prev_done) check("done_to_idle", 32'(fsm_state), 32'd0);
                if (err) check("err_with_valid", 32'(wb_valid), 32'd1);
                if (wb_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_wb", 32'(wb_data), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("wb_data", 32'(wb_data), 32'(e[15:0]));
                        check("wb_reg_wen", 32'(wb_reg_wen), 32'(e[20]));
                        check("wb_err", 32'(err), 32'(e[21]));
                        if (e[22]) check("wb_reg_waddr", 32'(wb_reg_waddr), 32'(e[19:16]));
                    end
                end
            end
            prev_done = (fsm_state == 2'd2);
        end
    end

    // Data-memory responder: checks each request and acks on the scheduled ACCESS cycle.
    initial begin
        logic     prev_req;
        logic     cur_valid;
        mem_exp_t cur;
        int       n;
        prev_req  = 1'b0;
        cur_valid = 1'b0;
        n         = 0;
        dmem_bus.ack   = 1'b0;
        dmem_bus.rdata = 16'h0000;
        forever begin
            @(posedge clk);
            #2;
            if (dmem_bus.req) begin
                if (!prev_req) begin
                    n = 0;
                    if (mem_q.size() == 0) begin
                        cur_valid = 1'b0;
                        check("unexpected_req", 32'd1, 32'd0);
                    end else begin
                        cur       = mem_q.pop_front();
                        cur_valid = 1'b1;
                    end
                end
                n++;
                if (cur_valid) begin
                    check("dmem_we", 32'(dmem_bus.we), 32'(cur.we));
                    check("dmem_addr", 32'(dmem_bus.addr), 32'(cur.addr));
                    check("dmem_wdata", 32'(dmem_bus.wdata), 32'(cur.wdata));
                end
                dmem_bus.ack   = cur_valid && (cur.ack_at == n);
                dmem_bus.rdata = dmem_bus.ack ? cur.rdata : 16'hDEAD;
            end else begin
                if (prev_req && cur_valid) check("req_len", 32'(n), 32'(cur.req_len));
                dmem_bus.ack   = stray_ack;
                dmem_bus.rdata = 16'h5A5A;
            end
            prev_req = dmem_bus.req;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_data", 32'(wb_data), 32'd0);
        check("rst_wb_reg_wen", 32'(wb_reg_wen), 32'd0);
        check("rst_wb_reg_waddr", 32'(wb_reg_waddr), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_dmem_req", 32'(dmem_bus.req), 32'd0);
        check("rst_dmem_we", 32'(dmem_bus.we), 32'd0);
        check("rst_dmem_addr", 32'(dmem_bus.addr), 32'd0);
        check("rst_dmem_wdata", 32'(dmem_bus.wdata), 32'd0);
        check("rst_state", 32'(fsm_state), 32'd0);
        rst = 1'b0;

        // ALU pass-through
        issue(16'h1234, 16'h0, 0, 0, 0, 1, 4'd5, 0, mk(1, 0, 1, 4'd5, 16'h1234));
        // Load, ack on 3rd ACCESS cycle
        add_mem(0, 16'h0040, 16'h5555, 16'hBEEF, 3, 3);
        issue(16'h0040, 16'h5555, 0, 1, 1, 1, 4'd3, 4, mk(1, 0, 1, 4'd3, 16'hBEEF));
        // Store acked immediately, then ALU op back-to-back
        add_mem(1, 16'h0010, 16'h00AA, 16'h1111, 1, 1);
        issue(16'h0010, 16'h00AA, 1, 0, 0, 0, 4'd0, 2, mk(1, 0, 0, 4'd0, 16'h0010));
        issue(16'h0007, 16'h0, 0, 0, 0, 1, 4'd2, 0, mk(1, 0, 1, 4'd2, 16'h0007));
        // Timeout, no ack
        add_mem(0, 16'h0080, 16'h0000, 16'h0000, 0, TO);
        issue(16'h0080, 16'h0, 0, 1, 1, 1, 4'd9, TO + 1, mk(0, 1, 0, 4'd0, 16'h0000));
        // Ack on the timeout cycle wins
        add_mem(0, 16'h00C0, 16'h0000, 16'hCAFE, TO, TO);
        issue(16'h00C0, 16'h0, 0, 1, 1, 1, 4'd12, TO + 1, mk(1, 0, 1, 4'd12, 16'hCAFE));
        // Both enables set: treated as a write
        add_mem(1, 16'h0020, 16'h3344, 16'h7777, 2, 2);
        issue(16'h0020, 16'h3344, 1, 1, 0, 0, 4'd1, 3, mk(1, 0, 0, 4'd1, 16'h0020));
        // Stray ack outside ACCESS is ignored
        stray_ack = 1'b1;
        issue(16'hFFFF, 16'h0, 0, 0, 0, 1, 4'd15, 0, mk(1, 0, 1, 4'd15, 16'hFFFF));
        add_mem(0, 16'h0200, 16'h0000, 16'h9999, 1, 1);
        issue(16'h0200, 16'h0, 0, 1, 0, 1, 4'd6, 2, mk(1, 0, 1, 4'd6, 16'h0200));
        stray_ack = 1'b0;

        // Reset on the 2nd ACCESS cycle
        add_mem(0, 16'h0300, 16'h0000, 16'h0000, 0, 2);
        alu_result = 16'h0300; rdata2 = 16'h0; mem_wen = 0; mem_ren = 1;
        mem_to_reg = 1; reg_wen = 1; reg_waddr = 4'd8;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("access_before_rst", 32'(fsm_state), 32'd1);
        rst = 1'b1;
        alu_result = 16'h0; mem_ren = 0; mem_to_reg = 0; reg_wen = 0; reg_waddr = 4'd0;
        @(posedge clk); #1;
        check("midrst_dmem_req", 32'(dmem_bus.req), 32'd0);
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_wb_valid", 32'(wb_valid), 32'd0);
        check("midrst_state", 32'(fsm_state), 32'd0);
        rst = 1'b0;
        // Later load gets a full fresh timeout window
        add_mem(0, 16'h0100, 16'h0000, 16'h0000, 0, TO);
        issue(16'h0100, 16'h0, 0, 1, 1, 1, 4'd4, TO + 1, mk(0, 1, 0, 4'd0, 16'h0000));
        issue(16'h0000, 16'h0, 0, 0, 0, 0, 4'd0, 0, mk(1, 0, 0, 4'd0, 16'h0000));

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("mem_q_drained", 32'(mem_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
